// File: rtl/ci_issue_master.sv
// Initiator for the multicycle custom-instruction interface: accepts an operand pair, pulses
// start, holds operands until the slave signals done (or a timeout expires), then hands off.
module ci_issue_master #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              clk_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              ci_start,
  output logic [DATA_W-1:0] ci_dataa,
  output logic [DATA_W-1:0] ci_datab,
  input  logic [DATA_W-1:0] ci_result,
  input  logic              ci_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_timeout,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  localparam int unsigned TmrW = $clog2(TIMEOUT);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic [DATA_W-1:0] dataa_q, dataa_d;
  logic [DATA_W-1:0] datab_q, datab_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      dataa_q   <= '0;
      datab_q   <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else if (clk_en) begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      dataa_q   <= dataa_d;
      datab_q   <= datab_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    dataa_d   = dataa_q;
    datab_d   = datab_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    count_d   = count_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          dataa_d = in_a;
          datab_d = in_b;
          timer_d = '0;
          state_d = StIssue;
        end
      end
      // Slaves register done, so any done seen during the start cycle is stale.
      StIssue: state_d = StWait;
      StWait: begin
        if (ci_done) begin
          result_d  = ci_result;
          timeout_d = 1'b0;
          state_d   = StHold;
        end else if (timer_q == TmrLast) begin
          result_d  = '0;
          timeout_d = 1'b1;
          state_d   = StHold;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StHold: begin
        if (out_ready) begin
          count_d = count_q + CNT_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready    = (state_q == StIdle);
  assign ci_start    = (state_q == StIssue);
  assign out_valid   = (state_q == StHold);
  assign busy        = (state_q != StIdle);
  assign ci_dataa    = dataa_q;
  assign ci_datab    = datab_q;
  assign out_result  = result_q;
  assign out_timeout = timeout_q;
  assign op_count    = count_q;

endmodule
